// File: rtl/change_gen_if.sv
// change_gen_if: event-in / Gray-bus-out bundle of the bus-change link.
// master = transmitter (change_gen), slave = event source / receiver side.
interface change_gen_if #(
    parameter int N      = 8,
    parameter int PEND_W = 4
);
    logic              event_in;
    logic              clr_ovf;
    logic [N-1:0]      dout;
    logic              change_stb;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        input  event_in, clr_ovf,
        output dout, change_stb, busy, pending, overflow
    );

    modport slave (
        output event_in, clr_ovf,
        input  dout, change_stb, busy, pending, overflow
    );
endinterface

// File: rtl/change_gen.sv
// change_gen: turns event pulses into single-bit Gray steps on a bus,
// spaced by a hold timer, with an event backlog and sticky drop flag.
module change_gen #(
    parameter int N           = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int PEND_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    change_gen_if.master   io_bus
);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

    logic [N-1:0]      r_bin;
    logic [N-1:0]      r_dout;
    logic [HW-1:0]     r_hold;
    logic [PEND_W-1:0] r_pend;
    logic              r_stb;
    logic              r_ovf;

    logic              w_ok;
    logic              w_want;
    logic              w_full;
    logic              w_has_pend;
    logic [N-1:0]      w_bin_nx;

    assign w_ok       = (r_hold == '0);
    assign w_has_pend = (r_pend != '0);
    assign w_want     = io_bus.event_in | w_has_pend;
    assign w_full     = &r_pend;
    assign w_bin_nx   = r_bin + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_dout <= '0;
            r_hold <= '0;
            r_pend <= '0;
            r_stb  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            // clear first so a same-cycle drop below wins
            if (io_bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_ok && w_want) begin
                r_bin  <= w_bin_nx;
                r_dout <= w_bin_nx ^ (w_bin_nx >> 1);
                r_stb  <= 1'b1;
                r_hold <= HOLD_RELOAD;
                if (w_has_pend && !io_bus.event_in) begin
                    r_pend <= r_pend - 1'b1;
                end
            end else if (!w_ok) begin
                r_hold <= r_hold - 1'b1;
                if (io_bus.event_in) begin
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_pend <= r_pend + 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.dout       = r_dout;
    assign io_bus.change_stb = r_stb;
    assign io_bus.busy       = (r_hold != '0) | w_has_pend;
    assign io_bus.pending    = r_pend;
    assign io_bus.overflow   = r_ovf;
endmodule

// File: tb/tb_change_gen.sv
// tb_change_gen: vector table, directed overflow/wrap/reset sequences and
// a scoreboarded random loopback through a bus-compare receiver.
module tb_change_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_gen_if #(.N(8), .PEND_W(4)) b8 ();
    change_gen_if #(.N(8), .PEND_W(2)) bp ();
    change_gen_if #(.N(3), .PEND_W(4)) bn ();

    change_gen #(.N(8), .HOLD_CYCLES(4), .PEND_W(4)) u8 (
        .clk(clk), .rst(rst), .io_bus(b8)
    );
    change_gen #(.N(8), .HOLD_CYCLES(4), .PEND_W(2)) up2 (
        .clk(clk), .rst(rst), .io_bus(bp)
    );
    change_gen #(.N(3), .HOLD_CYCLES(1), .PEND_W(4)) un3 (
        .clk(clk), .rst(rst), .io_bus(bn)
    );

    typedef struct {
        bit       rst;
        bit       ev;
        bit       clr;
        int       dout;
        bit       stb;
        bit       busy;
        int       pend;
        bit       ovf;
    } vec_t;

    vec_t vt[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    int   sbq[$];
    bit   sb_on   = 1'b0;
    int   rx_cnt  = 0;
    int   rx_prev = 0;

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(bit r, bit e, bit c, int d, bit s, bit b, int p, bit o);
        vec_t v;
        v = '{r, e, c, d, s, b, p, o};
        vt.push_back(v);
    endtask

    function automatic int gray8(int k);
        logic [7:0] b;
        b = k[7:0];
        return int'(b ^ (b >> 1));
    endfunction

    // receiver: bus-compare change detector plus scoreboard check
    always @(posedge clk) begin
        #1;
        if (sb_on) begin
            if (int'(b8.dout) != rx_prev) rx_cnt++;
            if (b8.change_stb) begin
                if (sbq.size() == 0) begin
                    chk("sb unexpected change", int'(b8.dout), -1);
                end else begin
                    chk("sb dout", int'(b8.dout), sbq.pop_front());
                end
                chk("sb onebit", $countones(b8.dout ^ rx_prev[7:0]), 1);
            end
            rx_prev = int'(b8.dout);
        end
    end

    initial begin
        int nchg;
        int prev;
        int ev_k;
        int exp_p[6]  = '{0, 1, 2, 3, 3, 3};
        int exp_d[6]  = '{1, 1, 1, 1, 3, 3};
        int seq3[8]   = '{1, 3, 2, 6, 7, 5, 4, 0};

        b8.event_in = 0; b8.clr_ovf = 0;
        bp.event_in = 0; bp.clr_ovf = 0;
        bn.event_in = 0; bn.clr_ovf = 0;

        // single event, then three back-to-back, then reset with backlog
        add(0,0,0,0,0,0,0,0);
        add(0,1,0,1,1,1,0,0);
        add(0,0,0,1,0,1,0,0);
        add(0,0,0,1,0,1,0,0);
        add(0,0,0,1,0,0,0,0);
        add(0,1,0,3,1,1,0,0);
        add(0,0,0,3,0,1,0,0);
        add(0,0,0,3,0,1,0,0);
        add(0,0,0,3,0,0,0,0);
        add(1,0,0,0,0,0,0,0);
        add(0,1,0,1,1,1,0,0);
        add(0,1,0,1,0,1,1,0);
        add(0,1,0,1,0,1,2,0);
        add(0,0,0,1,0,1,2,0);
        add(0,0,0,3,1,1,1,0);
        add(0,0,0,3,0,1,1,0);
        add(0,0,0,3,0,1,1,0);
        add(0,0,0,3,0,1,1,0);
        add(0,0,0,2,1,1,0,0);
        add(0,0,0,2,0,1,0,0);
        add(0,0,0,2,0,1,0,0);
        add(0,0,0,2,0,0,0,0);
        add(0,1,0,6,1,1,0,0);
        add(0,1,0,6,0,1,1,0);
        add(0,1,0,6,0,1,2,0);
        add(1,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0);

        tick();
        tick();
        rst = 0;
        chk("rst p2 pend", int'(bp.pending), 0);
        chk("rst p2 busy", int'(bp.busy), 0);
        chk("rst n3 dout", int'(bn.dout), 0);

        foreach (vt[i]) begin
            rst         = vt[i].rst;
            b8.event_in = vt[i].ev;
            b8.clr_ovf  = vt[i].clr;
            tick();
            chk($sformatf("v%0d dout", i), int'(b8.dout), vt[i].dout);
            chk($sformatf("v%0d stb", i), int'(b8.change_stb), int'(vt[i].stb));
            chk($sformatf("v%0d busy", i), int'(b8.busy), int'(vt[i].busy));
            chk($sformatf("v%0d pend", i), int'(b8.pending), vt[i].pend);
            chk($sformatf("v%0d ovf", i), int'(b8.overflow), int'(vt[i].ovf));
        end
        rst = 0; b8.event_in = 0; b8.clr_ovf = 0;

        // backlog overflow on the 2-bit pending counter
        rst = 1; tick(); rst = 0;
        nchg = 0;
        for (int i = 0; i < 6; i++) begin
            bp.event_in = 1;
            tick();
            if (bp.change_stb) nchg++;
            chk($sformatf("t3 pend%0d", i), int'(bp.pending), exp_p[i]);
            chk($sformatf("t3 dout%0d", i), int'(bp.dout), exp_d[i]);
            chk($sformatf("t3 ovf%0d", i), int'(bp.overflow), (i == 5) ? 1 : 0);
        end
        bp.event_in = 0;
        for (int c = 0; c < 40 && bp.busy; c++) begin
            tick();
            if (bp.change_stb) nchg++;
        end
        chk("t3 drained", int'(bp.busy), 0);
        chk("t3 changes", nchg, 5);
        chk("t3 final dout", int'(bp.dout), 7);
        chk("t3 ovf sticky", int'(bp.overflow), 1);
        bp.clr_ovf = 1; tick(); bp.clr_ovf = 0;
        chk("t3 clr", int'(bp.overflow), 0);
        for (int i = 0; i < 6; i++) begin
            bp.event_in = 1;
            bp.clr_ovf  = (i == 5);
            tick();
            chk($sformatf("t3b ovf%0d", i), int'(bp.overflow), (i == 5) ? 1 : 0);
        end
        bp.event_in = 0; bp.clr_ovf = 0;
        for (int c = 0; c < 40 && bp.busy; c++) tick();
        chk("t3b drained", int'(bp.busy), 0);
        bp.clr_ovf = 1; tick(); bp.clr_ovf = 0;
        chk("t3b clr", int'(bp.overflow), 0);

        // N=3, HOLD=1: one change per cycle, full wrap
        rst = 1; tick(); rst = 0;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            bn.event_in = 1;
            tick();
            chk($sformatf("t4 dout%0d", i), int'(bn.dout), seq3[i]);
            chk($sformatf("t4 stb%0d", i), int'(bn.change_stb), 1);
            chk($sformatf("t4 pend%0d", i), int'(bn.pending), 0);
            chk($sformatf("t4 onebit%0d", i), $countones(bn.dout ^ prev[2:0]), 1);
            prev = int'(bn.dout);
        end
        bn.event_in = 0;
        tick();
        chk("t4 idle stb", int'(bn.change_stb), 0);
        chk("t4 idle busy", int'(bn.busy), 0);

        // random loopback at no more than one event per HOLD cycles
        rst = 1; tick(); rst = 0;
        rx_prev = 0; rx_cnt = 0; ev_k = 0;
        sb_on = 1;
        for (int i = 0; i < 40; i++) begin
            ev_k++;
            sbq.push_back(gray8(ev_k));
            b8.event_in = 1;
            tick();
            b8.event_in = 0;
            repeat ($urandom_range(3, 6)) tick();
        end
        repeat (6) tick();
        sb_on = 0;
        chk("t6 rx count", rx_cnt, ev_k);
        chk("t6 queue empty", sbq.size(), 0);
        chk("t6 ovf", int'(b8.overflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
